// File: rtl/sram_b_stream_reader.sv
// sram_b_stream_reader: sequential SRAM read-port client returning data as a valid/ready stream
// Ports: CLK/RST (async active-high) | start, base_addr, length: command, accepted in IDLE
//        busy, done: command status | CE1, A1, Q1: SRAM read port 1 (Q1 one cycle after CE1)
//        out_valid, out_ready, out_data: output stream fed from a 2-entry FIFO
module sram_b_stream_reader #(
  parameter int ABITS = 20,
  parameter int DBITS = 8,
  parameter int LBITS = 21
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [ABITS-1:0] base_addr,
  input  logic [LBITS-1:0] length,
  output logic             busy,
  output logic             done,
  output logic             CE1,
  output logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] Q1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DBITS-1:0] out_data
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [LBITS-1:0] rem_q, rem_d;
  logic [1:0] occ_q, occ_d;
  logic [DBITS-1:0] head_q, head_d, tail_q, tail_d;
  logic inflight_q, busy_q, done_q, done_d, pop, push, ce;
  assign pop = out_valid && out_ready;
  assign push = inflight_q;
  // Issue only if the word still in flight and the current entries fit after this cycle's pop.
  assign ce = state_q == RUN && rem_q != '0 && (3'(occ_q) + 3'(inflight_q) < 3'd2 + 3'(pop));
  assign CE1 = ce;
  assign A1 = ce ? addr_q : '0;
  assign out_valid = occ_q != 2'd0;
  assign out_data = head_q;
  assign busy = busy_q;
  assign done = done_q;
  always_comb begin
    state_d = state_q;
    done_d = 1'b0;
    addr_d = ce ? addr_q + ABITS'(1) : addr_q;
    rem_d = ce ? rem_q - LBITS'(1) : rem_q;
    occ_d = occ_q + 2'(push) - 2'(pop);
    head_d = pop ? (occ_q == 2'd2 ? tail_q : (push ? Q1 : head_q)) : (push && occ_q == 2'd0 ? Q1 : head_q);
    tail_d = push && (occ_q - 2'(pop) == 2'd1) ? Q1 : tail_q;
    case (state_q)
      IDLE: begin
        if (start && length != '0) begin
          state_d = RUN;
          addr_d = base_addr;
          rem_d = length;
        end
        done_d = start && length == '0;
      end
      RUN: state_d = rem_d == '0 ? DRAIN : RUN;
      DRAIN: begin
        state_d = occ_d == 2'd0 ? IDLE : DRAIN;
        done_d = occ_d == 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      occ_q <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      inflight_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      occ_q <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      inflight_q <= ce;
      busy_q <= state_d != IDLE;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_sram_b_stream_reader.sv
// tb_sram_b_stream_reader: directed checks of the stream reader against a behavioural SRAM
module tb_sram_b_stream_reader;
  logic CLK = 0, RST = 1, start = 0, out_ready = 1;
  logic [19:0] base_addr = '0;
  logic [20:0] length = '0;
  logic busy, done, CE1, out_valid;
  logic [19:0] A1;
  logic [7:0] Q1 = '0, out_data;
  int vectors = 0, miscompares = 0;
  int fv, dc;

  sram_b_stream_reader dut (
    .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .CE1(CE1), .A1(A1), .Q1(Q1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mem_f(logic [19:0] a);
    return (a[7:0] ^ 8'h5A) + a[19:12];
  endfunction

  always @(posedge CLK) Q1 <= CE1 ? mem_f(A1) : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_cmd(input logic [19:0] base, input logic [20:0] len, input logic [15:0] rdy,
                         input int rs, output int first_v, output int done_c);
    int beats, ces, occ_m;
    logic prev_ce, prev_stall, pop;
    logic [7:0] prev_d;
    logic [19:0] exp_a;
    beats = 0; ces = 0; occ_m = 0; prev_ce = 0; prev_stall = 0; prev_d = '0;
    exp_a = base; first_v = -1; done_c = -1;
    base_addr = base; length = len; start = 1;
    step();
    for (int c = 0; c < 100; c++) begin
      out_ready = rdy[c % 16];
      start = (c == rs);
      base_addr = (c == rs) ? base + 20'h08000 : base;
      length = (c == rs) ? 21'd3 : len;
      #1;
      pop = out_valid && out_ready;
      if (done) begin
        done_c = c;
        chk("done_busy", {31'd0, busy}, 0);
        chk("done_valid", {31'd0, out_valid}, 0);
        break;
      end
      chk("busy", {31'd0, busy}, 1);
      chk("ce1", {31'd0, CE1}, {31'd0, (ces < int'(len)) && (occ_m + int'(prev_ce) - int'(pop) < 2)});
      if (CE1) begin
        chk("a1", {12'd0, A1}, {12'd0, exp_a});
        exp_a++;
        ces++;
      end
      chk("valid", {31'd0, out_valid}, {31'd0, occ_m != 0});
      if (out_valid && first_v < 0) first_v = c;
      if (prev_stall) chk("stall_data", {24'd0, out_data}, {24'd0, prev_d});
      if (pop) begin
        chk("beat", {24'd0, out_data}, {24'd0, mem_f(base + 20'(beats))});
        beats++;
      end
      occ_m = occ_m + int'(prev_ce) - int'(pop);
      prev_ce = CE1;
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      step();
    end
    start = 0;
    out_ready = 1;
    chk("beat_count", beats, {11'd0, len});
    chk("ce_count", ces, {11'd0, len});
    chk("done_seen", {31'd0, done_c >= 0}, 1);
    step();
    chk("done_pulse", {31'd0, done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_ce1", {31'd0, CE1}, 0);
    chk("rst_a1", {12'd0, A1}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    step();
    RST = 0;
    step();
    // basic 4-beat read at full throughput
    run_cmd(20'h00010, 21'd4, 16'hFFFF, -1, fv, dc);
    chk("t1_first_valid", fv, 2);
    chk("t1_done_cycle", dc, 6);
    // consumer stalls in a 1-0-0-1 pattern
    run_cmd(20'h00400, 21'd6, 16'h9999, -1, fv, dc);
    // heavier stalls
    run_cmd(20'h12345, 21'd5, 16'h1111, -1, fv, dc);
    // address wrap at the top of the space
    run_cmd(20'hFFFFE, 21'd4, 16'hFFFF, -1, fv, dc);
    chk("t3_done_cycle", dc, 6);
    // zero-length command
    length = 21'd0; base_addr = 20'h00050; start = 1;
    #1;
    chk("z_ce1_T", {31'd0, CE1}, 0);
    step();
    start = 0;
    chk("z_done", {31'd0, done}, 1);
    chk("z_busy", {31'd0, busy}, 0);
    chk("z_ce1", {31'd0, CE1}, 0);
    chk("z_valid", {31'd0, out_valid}, 0);
    step();
    chk("z_done_pulse", {31'd0, done}, 0);
    chk("z_busy2", {31'd0, busy}, 0);
    // second start during RUN must be ignored
    run_cmd(20'h00100, 21'd5, 16'hFFFF, 2, fv, dc);
    chk("t5_done_cycle", dc, 7);
    chk("t5_idle_busy", {31'd0, busy}, 0);
    // asynchronous reset with two beats buffered
    out_ready = 0; base_addr = 20'h00200; length = 21'd8; start = 1;
    step();
    start = 0;
    step(); step(); step();
    chk("r_buffered", {31'd0, out_valid}, 1);
    chk("r_stalled_ce", {31'd0, CE1}, 0);
    chk("r_head", {24'd0, out_data}, {24'd0, mem_f(20'h00200)});
    RST = 1;
    #1;
    chk("r_valid", {31'd0, out_valid}, 0);
    chk("r_ce1", {31'd0, CE1}, 0);
    chk("r_busy", {31'd0, busy}, 0);
    chk("r_data", {24'd0, out_data}, 0);
    chk("r_a1", {12'd0, A1}, 0);
    step();
    RST = 0;
    out_ready = 1;
    step();
    run_cmd(20'h00300, 21'd2, 16'hFFFF, -1, fv, dc);
    chk("r_done_cycle", dc, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
